program_dumper: RTL and testbench

//  Readback counterpart of the program loader. On a start pulse it reads the

---
 rtl/program_dumper.sv | 120 ++++++++++++
 tb/tb_program_dumper.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_dumper.sv
// Memory readback streamer: reads start_addr..end_addr (inclusive, wrapping)
// from a synchronous-read memory and emits (addr, data) beats over valid/ready.
module program_dumper #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  busy,
  output logic                  dump_done,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT,
    SEND
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] end_q, end_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n, out_addr_n;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic                  busy_n, dump_done_n, mem_read_n, out_valid_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      end_q     <= '0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      end_q     <= end_n;
      busy      <= busy_n;
      dump_done <= dump_done_n;
      mem_read  <= mem_read_n;
      mem_addr  <= mem_addr_n;
      out_valid <= out_valid_n;
      out_addr  <= out_addr_n;
      out_data  <= out_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    end_n       = end_q;
    busy_n      = busy;
    dump_done_n = dump_done;
    mem_read_n  = mem_read;
    mem_addr_n  = mem_addr;
    out_valid_n = out_valid;
    out_addr_n  = out_addr;
    out_data_n  = out_data;

    // abort outranks every other transition but is meaningless when idle
    if (abort && state != IDLE) begin
      state_n     = IDLE;
      busy_n      = 1'b0;
      mem_read_n  = 1'b0;
      out_valid_n = 1'b0;
      dump_done_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_done_n = 1'b0;
          if (start) begin
            mem_addr_n = start_addr;
            end_n      = end_addr;
            mem_read_n = 1'b1;
            busy_n     = 1'b1;
            state_n    = READ;
          end
        end
        READ: begin
          mem_read_n = 1'b0;
          state_n    = CAPT;
        end
        CAPT: begin
          out_data_n  = mem_rdata;
          out_addr_n  = mem_addr;
          out_valid_n = 1'b1;
          state_n     = SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            if (mem_addr == end_q) begin
              busy_n      = 1'b0;
              dump_done_n = 1'b1;
              state_n     = IDLE;
            end else begin
              mem_addr_n = mem_addr + ADDR_WIDTH'(1);
              mem_read_n = 1'b1;
              state_n    = READ;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_dumper.sv
// Randomized self-checking bench for program_dumper; expected beats come from
// an address-range model over a local memory array.
module tb_program_dumper;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] start_addr, end_addr, mem_addr, out_addr;
  logic          busy, dump_done, mem_read, out_valid;
  logic [DW-1:0] mem_rdata, out_data;

  logic [DW-1:0] mem [32];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    hs_q[$];
  int    total = 0, bad = 0, cyc = 0, beats = 0, dones = 0;

  logic          prev_stall = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;

  program_dumper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .busy(busy),
    .dump_done(dump_done), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) if (mem_read) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observes handshakes and protocol invariants between active edges
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_addr", 32'(out_addr), 32'(held_a));
        check("stall_data", 32'(out_data), 32'(held_d));
      end
      if (out_valid) check("no_read_in_send", 32'(mem_read), 0);
      check("done_not_busy", 32'(dump_done && busy), 0);
      if (dump_done) begin
        check("done_width", 32'(prev_done), 0);
        check("done_q_empty", exp_q.size(), 0);
        dones++;
      end
      if (out_valid && out_ready && !abort) begin
        beats++;
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("beat_addr", 32'(out_addr), 32'(exp_q[0].a));
          check("beat_data", 32'(out_data), 32'(exp_q[0].d));
          void'(exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready && !abort;
      held_a     = out_addr;
      held_d     = out_data;
      prev_done  = dump_done;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_counts();
    beats = 0;
    dones = 0;
    hs_q.delete();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  // Queues the whole expected range, then pulses start for one edge
  task automatic begin_dump(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    beat_t b;
    a = s;
    for (int k = 0; k < 32; k++) begin
      b.a = a;
      b.d = mem[a];
      exp_q.push_back(b);
      if (a == e) break;
      a = a + 1'b1;
    end
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd);
    int n = 0;
    while (busy && n < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    check(tag, 32'(n < budget), 1);
    tick();
    tick();
  endtask

  task automatic wait_beat(input string tag, input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (!(out_valid && out_addr == a) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic check_gap(input string tag, input int i, input int exp);
    if (i < hs_q.size()) check(tag, hs_q[i] - hs_q[i-1], exp);
    else check({tag, "_missing"}, hs_q.size(), i + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] s, e;
    int            n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start_addr = '0; end_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h10 + i);
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(dump_done), 0);
    check("rst_read", 32'(mem_read), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_maddr", 32'(mem_addr), 0);
    check("rst_oaddr", 32'(out_addr), 0);
    check("rst_odata", 32'(out_data), 0);
    reset = 1'b0;
    tick();

    // 1: basic 0..3 with latency and throughput
    reset_counts();
    begin_dump(5'd0, 5'd3);
    check("t1_busy", 32'(busy), 1);
    check("t1_read_n", 32'(mem_read), 1);
    check("t1_maddr", 32'(mem_addr), 0);
    tick();
    check("t1_read_n1", 32'(mem_read), 0);
    check("t1_valid_n1", 32'(out_valid), 0);
    tick();
    check("t1_valid_n2", 32'(out_valid), 1);
    check("t1_addr0", 32'(out_addr), 0);
    check("t1_data0", 32'(out_data), 32'h10);
    wait_idle("t1_idle", 200, 1'b0);
    check("t1_beats", beats, 4);
    check("t1_dones", dones, 1);
    for (int i = 1; i < 4; i++) check_gap("t1_gap", i, 3);

    // 2: stall on beat 2 for five cycles
    reset_counts();
    begin_dump(5'd0, 5'd3);
    wait_beat("t2_beat2", 5'd2, 100);
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    wait_idle("t2_idle", 200, 1'b0);
    check("t2_beats", beats, 4);
    check_gap("t2_gap_stall", 2, 8);
    check_gap("t2_gap_after", 3, 3);

    // 3: wrap 30..1
    randomize_mem();
    reset_counts();
    begin_dump(5'd30, 5'd1);
    wait_idle("t3_idle", 300, 1'b1);
    check("t3_beats", beats, 4);
    check("t3_dones", dones, 1);
    check("t3_q", exp_q.size(), 0);

    // 4: single beat, second start while busy ignored
    reset_counts();
    begin_dump(5'd7, 5'd7);
    start_addr = 5'd0; end_addr = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t4_idle", 100, 1'b0);
    check("t4_beats", beats, 1);
    check("t4_dones", dones, 1);
    check("t4_busy", 32'(busy), 0);

    // 5: abort during SEND of beat 1, then 5..5
    reset_counts();
    begin_dump(5'd0, 5'd31);
    wait_beat("t5_beat1", 5'd1, 100);
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    check("t5_valid", 32'(out_valid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_read", 32'(mem_read), 0);
    check("t5_done", 32'(dump_done), 0);
    repeat (5) tick();
    check("t5_dones", dones, 0);
    check("t5_beats", beats, 1);
    reset_counts();
    begin_dump(5'd5, 5'd5);
    wait_idle("t5_idle", 100, 1'b0);
    check("t5_beats2", beats, 1);
    check("t5_dones2", dones, 1);

    // 6: reset mid-READ
    reset_counts();
    begin_dump(5'd0, 5'd31);
    reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_read", 32'(mem_read), 0);
    check("t6_maddr", 32'(mem_addr), 0);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_oaddr", 32'(out_addr), 0);
    check("t6_odata", 32'(out_data), 0);
    check("t6_done", 32'(dump_done), 0);
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    repeat (6) tick();
    check("t6_beats", beats, 0);
    check("t6_dones", dones, 0);
    check("t6_idle_busy", 32'(busy), 0);

    // Random ranges and random back-pressure
    for (int r = 0; r < 8; r++) begin
      randomize_mem();
      s = 5'($urandom);
      e = 5'($urandom);
      n = int'(5'(e - s)) + 1;
      reset_counts();
      begin_dump(s, e);
      wait_idle("rnd_idle", 3000, 1'b1);
      check("rnd_beats", beats, n);
      check("rnd_dones", dones, 1);
      check("rnd_q", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
